prefetch_queue: RTL

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/prefetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and defaults for the prefetch queue.
package cpu_pkg;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_LO  = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI  = 32'h0000_6ffc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Misaligned or outside the text window: never sent to memory.
  function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch-entry storage: circular buffer with count and a flush-clear input.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop    = pop && (count != '0);
  // A pop in the same cycle frees the slot, so push into a full queue is legal then.
  assign do_push   = push && ((count < CW'(DEPTH)) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch: sequential fetch PC, one outstanding memory read,
// flush/redirect handling and an in-order queue toward decode.
module prefetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = DEF_PC_RESET,
  parameter logic [31:0] TEXT_LO  = DEF_TEXT_LO,
  parameter logic [31:0] TEXT_HI  = DEF_TEXT_HI,
  parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  out_exc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fpc;
  logic [31:0]  req_pc;
  logic         outstanding;
  logic         discard;
  logic [CW-1:0] count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         flush;
  logic [31:0]  flush_target;
  logic         pop;
  logic         slot_ok;
  logic         fpc_bad;
  logic         fetch_go;
  logic         issue;
  logic         exc_push;
  logic         rsp_push;

  assign flush = req || eret || redirect;

  always_comb begin
    flush_target = redirect_pc;
    if (req)       flush_target = EXC_VEC;
    else if (eret) flush_target = epc;
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign slot_ok   = (count < CW'(DEPTH)) || pop;
  assign fpc_bad   = fetch_addr_bad(fpc, TEXT_LO, TEXT_HI);

  // With nothing outstanding, the only pending push is the one this slot reserves.
  assign fetch_go = !reset && !flush && !outstanding && slot_ok;
  assign issue    = fetch_go && !fpc_bad;
  assign exc_push = fetch_go && fpc_bad;
  assign rsp_push = !reset && !flush && outstanding && !discard && imem_rvalid;

  assign imem_req  = issue;
  assign imem_addr = fpc;

  always_comb begin
    push_entry = '{pc: fpc, instr: '0, exc: EXC_ADEL};
    if (rsp_push) push_entry = '{pc: req_pc, instr: imem_rdata, exc: EXC_NONE};
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (exc_push || rsp_push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_exc   = head.exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= PC_RESET;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      // A request caught by a flush stays outstanding so nothing new issues until it drains.
      if (outstanding && imem_rvalid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding && flush) begin
        discard <= 1'b1;
      end
      if (issue) begin
        outstanding <= 1'b1;
        req_pc      <= fpc;
      end
      if (flush)         fpc <= flush_target;
      else if (fetch_go) fpc <= fpc + 32'd4;
    end
  end

endmodule
